// File: rtl/arm_multicycle_ctrl.sv
// Multicycle controller for the ARM-subset datapath: Moore FSM, NZCV flags, condition check, datapath selects.
// Latency: DP 4, LDR 5, STR 4, B/BL 3, Op=11 2 cycles; no backpressure, one instruction in flight.
module arm_multicycle_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         LinkWrite,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ImmSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ALUControl,
    output logic [1:0]   ResultSrc,
    output logic [3:0]   State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state;
    logic [3:0] flags;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    // ALU decoder; unknown Funct codes fall back to a silent ADD
    logic [1:0] dec_alu_op;
    logic       no_write;
    logic       known_op;
    logic       arith_op;
    logic [1:0] flag_w;

    always_comb begin
        dec_alu_op = 2'b00;
        no_write   = 1'b0;
        known_op   = 1'b1;
        arith_op   = 1'b0;
        case (funct[4:1])
            4'b0100: arith_op = 1'b1;
            4'b0010: begin dec_alu_op = 2'b01; arith_op = 1'b1; end
            4'b0000: dec_alu_op = 2'b10;
            4'b1100: dec_alu_op = 2'b11;
            4'b1010: begin dec_alu_op = 2'b01; no_write = 1'b1; arith_op = 1'b1; end
            default: begin no_write = 1'b1; known_op = 1'b0; end
        endcase
        flag_w[1] = funct[0] & known_op;
        flag_w[0] = funct[0] & arith_op;
    end

    logic n_f, z_f, c_f, v_f, cond_ex;
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            if ((state == EXECUTER || state == EXECUTEI) && cond_ex) begin
                if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
                if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
            end
            case (state)
                FETCH:    state <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECUTEI : EXECUTER;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR:   state <= funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    logic reg_w, mem_w, branch;

    always_comb begin
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ResultSrc  = 2'b00;
        case (state)
            FETCH, DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECUTER: ALUControl = dec_alu_op;
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dec_alu_op;
            end
            ALUWB:    reg_w = ~no_write;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are held off for the whole reset pulse, not just until the edge
    assign RegWrite  = ~reset & reg_w & cond_ex;
    assign MemWrite  = ~reset & mem_w & cond_ex;
    assign LinkWrite = ~reset & branch & funct[4] & cond_ex;
    assign IRWrite   = ~reset & (state == FETCH);
    assign PCWrite   = ~reset & ((state == FETCH) |
                                 (cond_ex & (branch | (reg_w & (rd == 4'hF)))));

    assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign ImmSrc = op;
    assign State  = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl: per-cycle expected control words queued, then compared each cycle.
module tb_arm_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, LinkWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
    logic [3:0]  State;

    arm_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .LinkWrite  (LinkWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       pcw, irw, memw, regw, lnk, adr;
        logic [1:0] rsrc, aluc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_cyc(input logic [3:0] st, input logic pcw, input logic irw,
                              input logic memw, input logic regw, input logic lnk,
                              input logic adr, input logic [1:0] rsrc, input logic [1:0] aluc);
        exp_t e;
        e.st = st; e.pcw = pcw; e.irw = irw; e.memw = memw; e.regw = regw;
        e.lnk = lnk; e.adr = adr; e.rsrc = rsrc; e.aluc = aluc;
        sb.push_back(e);
    endtask

    task automatic expect_fetch_decode();
        expect_cyc(4'd0, 1, 1, 0, 0, 0, 1'b0, 2'b10, 2'b00);
        expect_cyc(4'd1, 0, 0, 0, 0, 0, 1'bx, 2'b10, 2'b00);
    endtask

    // Called just after a rising edge with the DUT in FETCH; drains the scoreboard one cycle per entry
    task automatic run_instr(input string name, input logic [31:0] instr, input logic [3:0] aflags);
        exp_t e;
        Instr    = instr[31:12];
        ALUFlags = aflags;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            chk({name, ".state"}, State, e.st);
            chk({name, ".pcwrite"}, PCWrite, e.pcw);
            chk({name, ".irwrite"}, IRWrite, e.irw);
            chk({name, ".memwrite"}, MemWrite, e.memw);
            chk({name, ".regwrite"}, RegWrite, e.regw);
            chk({name, ".linkwrite"}, LinkWrite, e.lnk);
            if (!$isunknown(e.adr))  chk({name, ".adrsrc"}, AdrSrc, e.adr);
            if (!$isunknown(e.rsrc)) chk({name, ".resultsrc"}, ResultSrc, e.rsrc);
            if (!$isunknown(e.aluc)) chk({name, ".alucontrol"}, ALUControl, e.aluc);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = 4'b0000;
        #3;
        chk("rst.state", State, 4'd0);
        chk("rst.pcwrite", PCWrite, 1'b0);
        chk("rst.irwrite", IRWrite, 1'b0);
        chk("rst.flags", dut.flags, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD R0,R0,R2
        expect_fetch_decode();
        expect_cyc(4'd6, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        expect_cyc(4'd8, 0, 0, 0, 1, 0, 1'bx, 2'b00, 2'bxx);
        run_instr("add", 32'hE0800002, 4'b0000);

        // LDR R0,[R1,#4]
        expect_fetch_decode();
        expect_cyc(4'd2, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        expect_cyc(4'd3, 0, 0, 0, 0, 0, 1'b1, 2'bxx, 2'bxx);
        expect_cyc(4'd4, 0, 0, 0, 1, 0, 1'b1, 2'b01, 2'bxx);
        run_instr("ldr", 32'hE5910004, 4'b0000);

        // STREQ with Z clear: full sequence, no write
        expect_fetch_decode();
        expect_cyc(4'd2, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        expect_cyc(4'd5, 0, 0, 0, 0, 0, 1'b1, 2'bxx, 2'bxx);
        run_instr("streq", 32'h05810000, 4'b0100);
        chk("streq.regsrc", RegSrc, 2'b10);
        chk("streq.immsrc", ImmSrc, 2'b01);
        chk("streq.flags", dut.flags, 4'b0000);

        // CMP R0,#5 with ALU reporting Z
        expect_fetch_decode();
        expect_cyc(4'd7, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b01);
        expect_cyc(4'd8, 0, 0, 0, 0, 0, 1'bx, 2'b00, 2'bxx);
        run_instr("cmp", 32'hE3500005, 4'b0100);
        chk("cmp.flags", dut.flags, 4'b0100);

        // BEQ taken
        expect_fetch_decode();
        expect_cyc(4'd9, 1, 0, 0, 0, 0, 1'bx, 2'b10, 2'b00);
        run_instr("beq", 32'h0A000002, 4'b0000);

        // ADDNE PC,... with Z set: no register or PC write
        expect_fetch_decode();
        expect_cyc(4'd6, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        expect_cyc(4'd8, 0, 0, 0, 0, 0, 1'bx, 2'b00, 2'bxx);
        run_instr("addne", 32'h1080F002, 4'b1111);
        chk("addne.flags", dut.flags, 4'b0100);

        // ORRS: logical op writes N,Z only
        expect_fetch_decode();
        expect_cyc(4'd6, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b11);
        expect_cyc(4'd8, 0, 0, 0, 1, 0, 1'bx, 2'b00, 2'bxx);
        run_instr("orrs", 32'hE1900000, 4'b1011);
        chk("orrs.flags", dut.flags, 4'b1000);

        // BL
        expect_fetch_decode();
        expect_cyc(4'd9, 1, 0, 0, 0, 1, 1'bx, 2'b10, 2'b00);
        run_instr("bl", 32'hEB000003, 4'b0000);
        chk("bl.regsrc", RegSrc, 2'b01);
        chk("bl.immsrc", ImmSrc, 2'b10);

        // ADD PC,R0,R2
        expect_fetch_decode();
        expect_cyc(4'd6, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        expect_cyc(4'd8, 1, 0, 0, 1, 0, 1'bx, 2'b00, 2'bxx);
        run_instr("addpc", 32'hE080F002, 4'b0000);

        // Op=11 returns straight to FETCH
        expect_fetch_decode();
        run_instr("nop", 32'hEC000000, 4'b0000);

        // STR interrupted by reset in MEMWRITE
        expect_fetch_decode();
        expect_cyc(4'd2, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        run_instr("str", 32'hE5810000, 4'b0000);
        chk("str.state", State, 4'd5);
        chk("str.memwrite", MemWrite, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst.state", State, 4'd0);
        chk("midrst.memwrite", MemWrite, 1'b0);
        chk("midrst.pcwrite", PCWrite, 1'b0);
        chk("midrst.irwrite", IRWrite, 1'b0);
        chk("midrst.flags", dut.flags, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        expect_fetch_decode();
        expect_cyc(4'd6, 0, 0, 0, 0, 0, 1'bx, 2'bxx, 2'b00);
        expect_cyc(4'd8, 0, 0, 0, 1, 0, 1'bx, 2'b00, 2'bxx);
        run_instr("add2", 32'hE0800002, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
